// File: rtl/gaussian_blur_stream_pkg.sv
// Shared constants for the streaming 3x3 blur: mode encoding, kernel weights
// and the rounding applied to the 16x-scaled kernel sum.
package blur_pkg;

  typedef enum logic {
    MODE_GAUSS  = 1'b0,
    MODE_BYPASS = 1'b1
  } blur_mode_e;

  localparam int K_CORNER    = 1;
  localparam int K_EDGE      = 2;
  localparam int K_CENTRE    = 4;
  localparam int ROUND_ADD   = 8;
  localparam int ROUND_SHIFT = 4;

  // Tap weight for window row r (0 = oldest) and column k (0 = oldest).
  function automatic int kernelWeight(input int r, input int k);
    if (r == 1 && k == 1) return K_CENTRE;
    else if (r == 1 || k == 1) return K_EDGE;
    else return K_CORNER;
  endfunction

endpackage

// File: rtl/gaussian_blur_stream_if.sv
// Pixel-in / result-out stream bundle using the busy/vld handshake.
interface gaussian_blur_stream_if #(
  parameter int CH    = 3,
  parameter int PIX_W = 8
);

  logic              i_mode;
  logic              i_rgb_vld;
  logic              i_rgb_busy;
  logic [CH*PIX_W:0] i_rgb_data;
  logic              o_result_vld;
  logic              o_result_busy;
  logic [CH*PIX_W:0] o_result_data;

  modport master (
    output i_mode, i_rgb_vld, i_rgb_data, o_result_busy,
    input  i_rgb_busy, o_result_vld, o_result_data
  );

  modport slave (
    input  i_mode, i_rgb_vld, i_rgb_data, o_result_busy,
    output i_rgb_busy, o_result_vld, o_result_data
  );

endinterface

// File: rtl/gaussian_blur_stream_line_buffer.sv
// Two-row line store: reading at a column returns rows r-2 and r-1, and a
// write pushes the column up by one row.
module blur_line_buffer
  import blur_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int DATA_W = 24
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(IMG_W)-1:0] i_col,
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W-1:0]        o_rowTop,
  output logic [DATA_W-1:0]        o_rowMid
);

  logic [DATA_W-1:0] r_lineTop [IMG_W];
  logic [DATA_W-1:0] r_lineMid [IMG_W];

  assign o_rowTop = r_lineTop[i_col];
  assign o_rowMid = r_lineMid[i_col];

  // Contents are don't-care after reset or SOF, so the storage has no reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_lineTop[i_col] <= r_lineMid[i_col];
      r_lineMid[i_col] <= i_data;
    end
  end

endmodule

// File: rtl/gaussian_blur_stream.sv
// Streaming 3x3 blur (Gaussian 1-2-1 or centre bypass) over raster-order
// pixels, emitting one registered result per fully populated window.
module gaussian_blur_stream
  import blur_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CH    = 3,
  parameter int PIX_W = 8
) (
  input logic                   i_clk,
  input logic                   i_rst,
  gaussian_blur_stream_if.slave bus
);

  localparam int PIXB  = CH * PIX_W;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int SUM_W = PIX_W + 4;

  logic [COL_W-1:0] r_col, w_col, w_colNext;
  logic [ROW_W-1:0] r_row, w_row, w_rowNext;
  logic [PIXB-1:0]  r_winA [3];
  logic [PIXB-1:0]  r_winB [3];
  logic [PIXB-1:0]  w_colC [3];
  logic [PIXB-1:0]  w_pix, w_top, w_mid, w_gauss, w_pixOut;
  logic             w_accept, w_sof, w_complete, w_eof;
  logic             r_vld;
  logic [PIXB:0]    r_data;

  assign w_accept = bus.i_rgb_vld && !bus.i_rgb_busy;
  assign w_sof    = bus.i_rgb_data[PIXB];
  assign w_pix    = bus.i_rgb_data[PIXB-1:0];

  // SOF relocates the incoming pixel to the frame origin, dropping any partial frame.
  assign w_col = w_sof ? '0 : r_col;
  assign w_row = w_sof ? '0 : r_row;

  always_comb begin
    w_colNext = w_col + 1'b1;
    w_rowNext = w_row;
    if (w_col == COL_W'(IMG_W - 1)) begin
      w_colNext = '0;
      w_rowNext = (w_row == ROW_W'(IMG_H - 1)) ? '0 : w_row + 1'b1;
    end
  end

  assign w_complete = (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
  assign w_eof      = (w_row == ROW_W'(IMG_H - 1)) && (w_col == COL_W'(IMG_W - 1));

  blur_line_buffer #(
    .IMG_W  (IMG_W),
    .DATA_W (PIXB)
  ) u_lineBuffer (
    .i_clk    (i_clk),
    .i_we     (w_accept),
    .i_col    (w_col),
    .i_data   (w_pix),
    .o_rowTop (w_top),
    .o_rowMid (w_mid)
  );

  // Window = two registered columns (A oldest, B) plus the column arriving now.
  assign w_colC[0] = w_top;
  assign w_colC[1] = w_mid;
  assign w_colC[2] = w_pix;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [PIX_W-1:0]       w_tap [3][3];
    logic [SUM_W-1:0]       w_sum, w_rnd;
    logic [ROUND_SHIFT-1:0] w_unusedRnd;

    always_comb begin
      for (int r = 0; r < 3; r++) begin
        w_tap[r][0] = r_winA[r][c*PIX_W +: PIX_W];
        w_tap[r][1] = r_winB[r][c*PIX_W +: PIX_W];
        w_tap[r][2] = w_colC[r][c*PIX_W +: PIX_W];
      end
    end

    always_comb begin
      w_sum = '0;
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          w_sum = w_sum + SUM_W'(kernelWeight(r, k)) * SUM_W'(w_tap[r][k]);
    end

    assign w_rnd       = w_sum + SUM_W'(ROUND_ADD);
    assign w_gauss[c*PIX_W +: PIX_W] = w_rnd[ROUND_SHIFT +: PIX_W];
    assign w_unusedRnd = w_rnd[ROUND_SHIFT-1:0];
  end

  assign w_pixOut = (blur_mode_e'(bus.i_mode) == MODE_BYPASS) ? r_winB[1] : w_gauss;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_col <= '0;
      r_row <= '0;
      for (int r = 0; r < 3; r++) begin
        r_winA[r] <= '0;
        r_winB[r] <= '0;
      end
    end else if (w_accept) begin
      r_col <= w_colNext;
      r_row <= w_rowNext;
      for (int r = 0; r < 3; r++) begin
        r_winA[r] <= r_winB[r];
        r_winB[r] <= w_colC[r];
      end
    end
  end

  // A completing pixel is only accepted when the register is free or draining,
  // so loading takes priority over clearing vld.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (w_accept && w_complete) begin
      r_vld  <= 1'b1;
      r_data <= {w_eof, w_pixOut};
    end else if (r_vld && !bus.o_result_busy) begin
      r_vld <= 1'b0;
    end
  end

  assign bus.i_rgb_busy    = r_vld && bus.o_result_busy;
  assign bus.o_result_vld  = r_vld;
  assign bus.o_result_data = r_data;

endmodule

// File: tb/tb_gaussian_blur_stream.sv
// Scoreboard bench: a 4x4 and a 5x5 instance fed from one stimulus process,
// expected results computed from a full-image reference model.
module tb_gaussian_blur_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gaussian_blur_stream_if #(.CH(3), .PIX_W(8)) bus4 ();
  gaussian_blur_stream_if #(.CH(3), .PIX_W(8)) bus5 ();

  gaussian_blur_stream #(.IMG_W(4), .IMG_H(4), .CH(3), .PIX_W(8)) dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4)
  );

  gaussian_blur_stream #(.IMG_W(5), .IMG_H(5), .CH(3), .PIX_W(8)) dut5 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus5)
  );

  int checks = 0;
  int errors = 0;
  int stallLeft = 0;
  int got4 = 0;
  int got5 = 0;
  int mcol [2];
  int mrow [2];
  logic [7:0]  img [2][8][8][3];
  logic [24:0] q4 [$];
  logic [24:0] q5 [$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dimOf(input int sel);
    return (sel == 0) ? 4 : 5;
  endfunction

  // Direct 3x3 convolution on the stored frame, window ending at (r, c).
  function automatic logic [24:0] modelResult(input int sel, input int r, input int c, input bit mode);
    logic [23:0] px;
    int sum, wgt;
    for (int ch = 0; ch < 3; ch++) begin
      if (mode) begin
        px[ch*8 +: 8] = img[sel][r-1][c-1][ch];
      end else begin
        sum = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++) begin
            wgt = ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
            sum += wgt * int'(img[sel][r-2+dr][c-2+dc][ch]);
          end
        px[ch*8 +: 8] = 8'((sum + 8) >> 4);
      end
    end
    return {(r == dimOf(sel) - 1) && (c == dimOf(sel) - 1), px};
  endfunction

  function automatic void modelAccept(input int sel, input bit sof, input bit mode, input logic [23:0] pix);
    int r, c;
    c = sof ? 0 : mcol[sel];
    r = sof ? 0 : mrow[sel];
    for (int ch = 0; ch < 3; ch++) img[sel][r][c][ch] = pix[ch*8 +: 8];
    if (r >= 2 && c >= 2) begin
      if (sel == 0) q4.push_back(modelResult(sel, r, c, mode));
      else          q5.push_back(modelResult(sel, r, c, mode));
    end
    if (c == dimOf(sel) - 1) begin
      mcol[sel] = 0;
      mrow[sel] = (r == dimOf(sel) - 1) ? 0 : r + 1;
    end else begin
      mcol[sel] = c + 1;
      mrow[sel] = r;
    end
  endfunction

  task automatic stallStep();
    bus4.o_result_busy = (stallLeft > 0);
    if (stallLeft > 0) stallLeft--;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus4.i_rgb_vld = 1'b0;
      bus5.i_rgb_vld = 1'b0;
      stallStep();
    end
  endtask

  // Presents one pixel until accepted, checking busy against the scoreboard each cycle.
  task automatic applyStimulus(input int sel, input bit sof, input bit mode, input logic [23:0] pix);
    bit accepted;
    bit busyNow;
    int guard;
    accepted = 1'b0;
    guard = 0;
    while (!accepted && guard < 50) begin
      @(negedge clk);
      stallStep();
      bus4.i_rgb_vld = (sel == 0);
      bus5.i_rgb_vld = (sel == 1);
      if (sel == 0) begin
        bus4.i_mode = mode;
        bus4.i_rgb_data = {sof, pix};
      end else begin
        bus5.i_mode = mode;
        bus5.i_rgb_data = {sof, pix};
      end
      #1;
      if (sel == 0) begin
        busyNow = bus4.i_rgb_busy;
        checkOutput("rgb_busy4", 32'(busyNow), 32'(bus4.o_result_busy && (q4.size() > 0)));
      end else begin
        busyNow = bus5.i_rgb_busy;
        checkOutput("rgb_busy5", 32'(busyNow), 32'd0);
      end
      if (!busyNow) begin
        accepted = 1'b1;
        modelAccept(sel, sof, mode, pix);
      end
      guard++;
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic resetModel();
    q4.delete();
    q5.delete();
    mcol = '{0, 0};
    mrow = '{0, 0};
  endtask

  always @(negedge clk) begin
    #2;
    if (bus4.o_result_vld) begin
      if (q4.size() == 0) checkOutput("unexpected4", 32'(bus4.o_result_data), 32'h1ffffff);
      else begin
        checkOutput("result4", 32'(bus4.o_result_data), 32'(q4[0]));
        if (!bus4.o_result_busy) begin
          void'(q4.pop_front());
          got4++;
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (bus5.o_result_vld) begin
      if (q5.size() == 0) checkOutput("unexpected5", 32'(bus5.o_result_data), 32'h1ffffff);
      else begin
        checkOutput("result5", 32'(bus5.o_result_data), 32'(q5[0]));
        if (!bus5.o_result_busy) begin
          void'(q5.pop_front());
          got5++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [23:0] px;
    rst = 1'b0;
    bus4.i_mode = 1'b0; bus4.i_rgb_vld = 1'b0; bus4.i_rgb_data = '0; bus4.o_result_busy = 1'b0;
    bus5.i_mode = 1'b0; bus5.i_rgb_vld = 1'b0; bus5.i_rgb_data = '0; bus5.o_result_busy = 1'b0;
    resetModel();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_vld4", 32'(bus4.o_result_vld), 32'd0);
    checkOutput("rst_data4", 32'(bus4.o_result_data), 32'd0);
    checkOutput("rst_busy4", 32'(bus4.i_rgb_busy), 32'd0);
    checkOutput("rst_vld5", 32'(bus5.o_result_vld), 32'd0);
    checkOutput("rst_data5", 32'(bus5.o_result_data), 32'd0);
    rst = 1'b1;

    $display("[TB] constant 100 frame, Gaussian");
    base = got4;
    for (int i = 0; i < 16; i++) applyStimulus(0, i == 0, 1'b0, {3{8'd100}});
    idleCycles(4);
    checkOutput("const_count", 32'(got4 - base), 32'd4);

    $display("[TB] 5x5 impulse, Gaussian");
    base = got5;
    for (int i = 0; i < 25; i++) applyStimulus(1, i == 0, 1'b0, (i == 12) ? {3{8'd255}} : 24'd0);
    idleCycles(4);
    checkOutput("impulse_count", 32'(got5 - base), 32'd9);

    $display("[TB] ramp frame, bypass");
    base = got4;
    for (int i = 0; i < 16; i++) applyStimulus(0, i == 0, 1'b1, {3{8'(i)}});
    idleCycles(4);
    checkOutput("bypass_count", 32'(got4 - base), 32'd4);

    $display("[TB] downstream stall for 5 cycles");
    base = got4;
    for (int i = 0; i < 16; i++) begin
      if (i == 11) stallLeft = 5;
      px = {8'(i * i), 8'(i * 13 + 3), 8'(i * 7)};
      applyStimulus(0, i == 0, 1'b0, px);
    end
    idleCycles(4);
    checkOutput("stall_count", 32'(got4 - base), 32'd4);

    $display("[TB] SOF restart at pixel 7");
    base = got4;
    for (int i = 0; i < 7; i++) applyStimulus(0, i == 0, 1'b0, {3{8'd200}});
    for (int i = 0; i < 16; i++) begin
      px = {8'(i * 17), 8'(255 - i * 9), 8'(i * 5 + 40)};
      applyStimulus(0, i == 0, 1'b0, px);
    end
    idleCycles(4);
    checkOutput("sof_count", 32'(got4 - base), 32'd4);

    $display("[TB] reset with a result pending");
    for (int i = 0; i < 16; i++) applyStimulus(0, i == 0, 1'b0, {3{8'(i * 11)}});
    @(negedge clk);
    bus4.i_rgb_vld = 1'b0;
    bus4.o_result_busy = 1'b1;
    rst = 1'b0;
    #1;
    checkOutput("vld_before_rst", 32'(bus4.o_result_vld), 32'd1);
    @(negedge clk);
    resetModel();
    rst = 1'b1;
    bus4.o_result_busy = 1'b0;
    #1;
    checkOutput("post_rst_vld", 32'(bus4.o_result_vld), 32'd0);
    checkOutput("post_rst_data", 32'(bus4.o_result_data), 32'd0);
    checkOutput("post_rst_busy", 32'(bus4.i_rgb_busy), 32'd0);
    base = got4;
    for (int i = 0; i < 16; i++) applyStimulus(0, 1'b0, i[0], {8'(i * 3), 8'(100 - i), 8'(i * 15)});
    idleCycles(5);
    checkOutput("rst_frame_count", 32'(got4 - base), 32'd4);

    checkOutput("q4_drained", 32'(q4.size()), 32'd0);
    checkOutput("q5_drained", 32'(q5.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gaussian_blur_stream.md
# gaussian_blur_stream

Parametrised streaming 3x3 blur engine, successor to the fixed-size Gaussian_Blur accelerator. It accepts one multi-channel pixel per transfer in raster order and buffers two image rows on chip. It emits one filtered pixel per fully populated 3x3 window, with valid windows only and no border padding. It uses the same busy/vld stream handshake as the existing accelerator ports, so it drops into the Stratus cosim top unchanged.

## Interface
Parameters:
- IMG_W, 8: pixels per row; minimum 3.
- IMG_H, 8: rows per frame; minimum 3.
- CH, 3: channels per pixel.
- PIX_W, 8: bits per channel.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset; synchronous, active-low.
- i_mode  in  1  0 = Gaussian 1-2-1 kernel, 1 = bypass (window centre pixel); sampled per accepted pixel.
- i_rgb_vld  in  1  input pixel valid.
- i_rgb_busy  out  1  block cannot accept a pixel this cycle.
- i_rgb_data  in  CH*PIX_W+1  bit [CH*PIX_W] = start-of-frame (SOF); channel c = bits [c*PIX_W +: PIX_W].
- o_result_vld  out  1  result valid.
- o_result_busy  in  1  downstream cannot accept.
- o_result_data  out  CH*PIX_W+1  bit [CH*PIX_W] = last result of frame (EOF); channels packed as on input.

## Operation
- Input transfer: i_rgb_vld && !i_rgb_busy. Output transfer: o_result_vld && !o_result_busy.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) advance on each input transfer. Col wraps at IMG_W-1 and increments row. Row wraps at IMG_H-1 to 0.
- SOF=1 on a transfer forces that pixel to col=0, row=0 and discards any partial frame; line buffer contents are don't-care.
- Line buffers: two rows of IMG_W pixels. Each transfer writes the pixel at col and shifts the column into a 3x3 window register (rows r-2, r-1, r).
- A window is complete when row>=2 and col>=2 for the pixel just accepted. Only complete windows produce a result. A frame yields (IMG_W-2)*(IMG_H-2) results.
- Gaussian, per channel: weights 1 2 1 / 2 4 2 / 1 2 1. Sum in PIX_W+4 bits, result = (sum + 8) >> 4. This cannot overflow: max (16*(2^PIX_W-1)+8)>>4 = 2^PIX_W-1.
- Bypass: result = centre pixel (row r-1, col-1).
- EOF bit = 1 when the completing pixel is row IMG_H-1, col IMG_W-1.

## Timing
- Reset (i_rst=0 at edge): o_result_vld=0, o_result_data=0, i_rgb_busy=0, counters 0, window cleared.
- Latency: result registered 1 cycle after the input transfer that completes the window.
- Single output register: i_rgb_busy = o_result_vld && o_result_busy, combinational, no input-to-busy path. An accepted pixel that completes a window while the output register is being drained loads the register in the same edge, giving full throughput of 1 pixel/cycle.
- Output holds data and vld stable while o_result_busy=1.
- Simultaneous output drain with an input that does not complete a window: o_result_vld falls to 0 next cycle.
- Reset mid-frame: in-flight result dropped; the next accepted pixel is row 0, col 0 regardless of SOF.
- i_rgb_vld=0 cycles: no state change except the output drain.

## Structure
- Package blur_pkg: mode constants MODE_GAUSS=0 and MODE_BYPASS=1, kernel weight constants, and the rounding constant 8 with shift 4.
- Sub-module blur_line_buffer: two-row storage, IMG_W deep, CH*PIX_W wide, one write and two reads per cycle at col. Instantiated once.
- Top holds counters, window registers, kernel arithmetic and the output register.

## Test plan
- Constant image 100/100/100 (all channels), 4x4, Gaussian -> 4 results, each 100/100/100, EOF on the 4th only.
- 5x5 image all 0 except centre = 255, Gaussian -> 9 results. The centre result is (1020+8)>>4 = 64. Edge-adjacent results are 32 and corners 16 (exact: (510+8)>>4 = 32, (255+8)>>4 = 16).
- 4x4 ramp (pixel = row*4+col), bypass -> results 5, 6, 9, 10 in order.
- o_result_busy held high for 5 cycles during a stream -> i_rgb_busy high from the first blocked cycle; o_result_data stable; no results lost or duplicated; order preserved.
- SOF asserted at pixel 7 of a 4x4 frame, followed by a full frame -> exactly 4 results, all from the new frame.
- i_rst=0 for one cycle while o_result_vld=1 -> next cycle all outputs 0; the following 16-pixel frame yields 4 correct results.
